dsp_seq_alu_wide: RTL and testbench
===================================

Name: dsp_seq_alu_wide

Overview:
Parametrised successor of the 4-bit sequential ALU. It accepts operands over a narrow DATA_W-bit bus as several least-significant-first beats per operand, then takes an opcode beat and executes one operation in a dedicated cycle. Compared with the 4-bit unit it adds:
- a wider opcode set, including carry-chained ADC/SBB for multi-precision arithmetic;
- an overflow flag;
- accumulator chaining, where the held result becomes op1;
- a synchronous abort.

It sits behind the same pin-limited io wrapper as the 4-bit ALU.

Parameters:
DATA_W, 4, input bus width per beat; must be at least 4 (the opcode is taken from data_in[3:0]).
OP_W, 8, operand/result width; must be a multiple of DATA_W. BEATS = OP_W/DATA_W.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
process  input  1  beat strobe; the current data_in is consumed on a clock edge where process=1 and ready=1.
abort  input  1  synchronous discard of the operation in progress.
acc_sel  input  1  sampled with the first op1 beat; 1 = use the held result as op1.
data_in  input  DATA_W  operand beat or opcode (opcode in [3:0], upper bits ignored).
result  output  OP_W  registered result.
flags  output  4  {N, Z, C, V}, registered.
done  output  1  high from the execute edge until the next accepted op1 beat (or acc_sel skip).
ready  output  1  high in the GET_OP1, GET_OP2 and GET_OPC states; low in EXEC.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - state=GET_OP1, result=0, flags=0, done=0, beat counter=0, op1/op2/opcode=0.
  - Outputs clear with no clock edge required.
- State machine, one-hot: GET_OP1 -> GET_OP2 -> GET_OPC -> EXEC -> GET_OP1.
- GET_OP1:
  - Each accepted beat stores data_in into op1 slice [cnt*DATA_W +: DATA_W] and increments cnt.
  - After BEATS beats: cnt=0, go to GET_OP2.
  - If acc_sel=1 on the first accepted strobe (cnt=0): op1=result, data_in is ignored, and the state goes directly to GET_OP2.
  - done clears on the first accepted strobe.
- GET_OP2: same beat collection into op2; after BEATS beats, go to GET_OPC.
- GET_OPC: one accepted beat latches opcode=data_in[3:0], then go to EXEC.
- EXEC:
  - Lasts one cycle and needs no process. process is ignored.
  - Latency: result, flags and done=1 are registered on the edge after the opcode edge. State then returns to GET_OP1.
- process=0 in any state: no state change, holds indefinitely.
- abort=1 (priority over process, not in EXEC):
  - Next edge: state=GET_OP1, cnt=0.
  - result, flags and done are held.
  - abort during EXEC is ignored; EXEC completes.
- Opcodes, operating on op1 (a) and op2 (b):
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 AND
  - 3 OR
  - 4 NOT a
  - 5 NAND
  - 6 NOR
  - 7 XOR
  - 8 ADC a+b+C
  - 9 SBB a-b-C
  - A SHL1 a
  - B SHR1 a (logical)
  - C ASR1 a
  - D CMP: flags computed as for SUB, result unchanged
  - E PASS b
  - F NOP: result unchanged, N/Z taken from the held result, C=V=0
- Flags:
  - N = new result MSB; Z = (new result == 0). For CMP, N/Z reflect a-b.
  - C:
    - add ops: carry out of bit OP_W-1;
    - sub ops/CMP: borrow, i.e. 1 when a < b (+C for SBB) unsigned;
    - SHL: bit shifted out at the MSB; SHR/ASR: old bit 0;
    - logic/PASS: 0.
  - V: signed two's-complement overflow for ADD/ADC/SUB/SBB/CMP; 0 otherwise.
- The C used by ADC/SBB is the flags.C held from the previous EXEC. It survives op collection and abort, and is cleared only by reset.
- All arithmetic is computed at OP_W+1 bits and truncated to OP_W for result.

Test Plan:
1. (OP_W=8, DATA_W=4) Beats F,7 | 1,0 | opcode 0 -> one cycle after the opcode edge: result=0x80, flags N=1 Z=0 C=0 V=1, done=1, ready=0 for exactly that cycle.
2. SUB with op1=0x10, op2=0x20 -> result=0xF0, N=1 Z=0 C=1 V=0. Follow with CMP 0x20,0x20 -> Z=1, C=0, result still 0xF0.
3. Chaining:
   - ADD 0xFF+0x01 -> result=0x00, Z=1, C=1.
   - Then first strobe with acc_sel=1, op2=0x00, opcode 8 (ADC) -> result=0x01, C=0, Z=0.
4. Strobe gaps and abort:
   - Deassert process for 5 cycles between every beat -> same results as back-to-back beats.
   - Assert abort after 3 beats -> next beat is treated as op1[3:0]; prior result/flags unchanged.
5. Shifts: ASR 0x81 -> result=0xC0, C=1, N=1. SHL 0x81 -> result=0x02, C=1. SHR 0x81 -> result=0x40, C=1, N=0.
6. Asynchronous reset: drop reset_n mid-GET_OP2 between clock edges -> result, flags and done go to 0 and ready=1 immediately. After release, a full ADD 0x03+0x04 gives 0x07 with C=0 (no stale carry).

Source files
------------

// File: rtl/dsp_seq_alu_wide_if.sv
// Beat bus of the wide sequential ALU: operand/opcode strobes in, registered result and status out.
// The master drives beats; the ALU sits on the slave side.
interface dsp_seq_alu_wide_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 8
);
  logic              process;
  logic              abort;
  logic              acc_sel;
  logic [DATA_W-1:0] data_in;
  logic [OP_W-1:0]   result;
  logic [3:0]        flags;
  logic              done;
  logic              ready;

  modport master (
    output process, abort, acc_sel, data_in,
    input  result, flags, done, ready
  );

  modport slave (
    input  process, abort, acc_sel, data_in,
    output result, flags, done, ready
  );
endinterface

// File: rtl/dsp_seq_alu_wide.sv
// Sequential ALU that collects two OP_W-bit operands as LSB-first DATA_W-bit beats plus an
// opcode beat, then executes in one dedicated cycle; supports carry chaining and accumulator reuse.
module dsp_seq_alu_wide #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dsp_seq_alu_wide_if.slave    bus
);
  localparam int BEATS = OP_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam int MSB = OP_W - 1;

  typedef enum logic [3:0] {
    GET_OP1 = 4'b0001,
    GET_OP2 = 4'b0010,
    GET_OPC = 4'b0100,
    EXEC    = 4'b1000
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_NOT  = 4'h4, OP_NAND = 4'h5, OP_NOR  = 4'h6, OP_XOR  = 4'h7,
    OP_ADC  = 4'h8, OP_SBB  = 4'h9, OP_SHL  = 4'hA, OP_SHR  = 4'hB,
    OP_ASR  = 4'hC, OP_CMP  = 4'hD, OP_PASS = 4'hE, OP_NOP  = 4'hF
  } opcode_t;

  state_t           state;
  opcode_t          opcode;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0]  op1, op2, result_q;
  logic [3:0]       flags_q;   // {N, Z, C, V}
  logic             done_q;

  logic [OP_W:0]    wide;
  logic [OP_W-1:0]  res_n, val;
  logic             c_n, v_n;
  logic             cin;

  assign cin = flags_q[1];

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    wide  = '0;
    res_n = result_q;
    val   = result_q;
    c_n   = 1'b0;
    v_n   = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        wide  = {1'b0, op1} + {1'b0, op2} + (OP_W+1)'(opcode == OP_ADC && cin);
        res_n = wide[MSB:0];
        val   = res_n;
        c_n   = wide[OP_W];
        v_n   = (op1[MSB] == op2[MSB]) && (res_n[MSB] != op1[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        // Top bit of the OP_W+1 difference is the unsigned borrow.
        wide = {1'b0, op1} - {1'b0, op2} - (OP_W+1)'(opcode == OP_SBB && cin);
        val  = wide[MSB:0];
        c_n  = wide[OP_W];
        v_n  = (op1[MSB] != op2[MSB]) && (val[MSB] != op1[MSB]);
        if (opcode != OP_CMP) res_n = val;
      end
      OP_AND:  begin res_n = op1 & op2;    val = res_n; end
      OP_OR:   begin res_n = op1 | op2;    val = res_n; end
      OP_NOT:  begin res_n = ~op1;         val = res_n; end
      OP_NAND: begin res_n = ~(op1 & op2); val = res_n; end
      OP_NOR:  begin res_n = ~(op1 | op2); val = res_n; end
      OP_XOR:  begin res_n = op1 ^ op2;    val = res_n; end
      OP_SHL:  begin res_n = {op1[MSB-1:0], 1'b0};   val = res_n; c_n = op1[MSB]; end
      OP_SHR:  begin res_n = {1'b0, op1[MSB:1]};     val = res_n; c_n = op1[0];   end
      OP_ASR:  begin res_n = {op1[MSB], op1[MSB:1]}; val = res_n; c_n = op1[0];   end
      OP_PASS: begin res_n = op2;          val = res_n; end
      default: ;  // NOP keeps result; N/Z come from it, C=V=0
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= GET_OP1;
      opcode   <= OP_ADD;
      cnt      <= '0;
      op1      <= '0;
      op2      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else if (state == EXEC) begin
      result_q <= res_n;
      flags_q  <= {val[MSB], (val == '0), c_n, v_n};
      done_q   <= 1'b1;
      state    <= GET_OP1;
    end else if (bus.abort) begin
      state <= GET_OP1;
      cnt   <= '0;
    end else if (bus.process) begin
      case (state)
        GET_OP1: begin
          done_q <= 1'b0;
          if (cnt == '0 && bus.acc_sel) begin
            op1   <= result_q;
            state <= GET_OP2;
          end else begin
            op1[cnt*DATA_W +: DATA_W] <= bus.data_in;
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              state <= GET_OP2;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        GET_OP2: begin
          op2[cnt*DATA_W +: DATA_W] <= bus.data_in;
          if (cnt == LAST_BEAT) begin
            cnt   <= '0;
            state <= GET_OPC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GET_OPC: begin
          opcode <= opcode_t'(bus.data_in[3:0]);
          state  <= EXEC;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign bus.done   = done_q;
  assign bus.ready  = (state != EXEC);
endmodule

// File: tb/tb_dsp_seq_alu_wide.sv
// Self-checking bench for dsp_seq_alu_wide (DATA_W=4, OP_W=8): directed vector table,
// hand-written abort/reset sequences and randomized ops against an arithmetic reference model.
module tb_dsp_seq_alu_wide;
  localparam int DATA_W = 4;
  localparam int OP_W   = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  // Reference state: held result, held flags {N,Z,C,V}.
  int         m_res;
  logic [3:0] m_flags;

  dsp_seq_alu_wide_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  dsp_seq_alu_wide #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc;
    logic [7:0] exp_res;
    logic [3:0] exp_flags;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Integer-arithmetic reference of one execute step.
  function automatic void ref_exec(input int op, input int a, input int b, input int cin,
                                   input int held, output int res, output logic [3:0] fl);
    int sa, sb, s, ss, val, c, v, ci;
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    res = held;
    val = held;
    c   = 0;
    v   = 0;
    case (op)
      0, 8: begin
        ci  = (op == 8) ? cin : 0;
        s   = a + b + ci;
        ss  = sa + sb + ci;
        res = s % 256;
        val = res;
        c   = (s > 255) ? 1 : 0;
        v   = (ss > 127 || ss < -128) ? 1 : 0;
      end
      1, 9, 13: begin
        ci  = (op == 9) ? cin : 0;
        s   = a - b - ci;
        ss  = sa - sb - ci;
        val = (s + 512) % 256;
        c   = (s < 0) ? 1 : 0;
        v   = (ss > 127 || ss < -128) ? 1 : 0;
        if (op != 13) res = val;
      end
      2:  begin res = a & b;         val = res; end
      3:  begin res = a | b;         val = res; end
      4:  begin res = 255 - a;       val = res; end
      5:  begin res = 255 - (a & b); val = res; end
      6:  begin res = 255 - (a | b); val = res; end
      7:  begin res = a ^ b;         val = res; end
      10: begin res = (a * 2) % 256; val = res; c = a / 128; end
      11: begin res = a / 2;         val = res; c = a % 2; end
      12: begin res = a / 2 + ((a >= 128) ? 128 : 0); val = res; c = a % 2; end
      14: begin res = b;             val = res; end
      default: ;
    endcase
    fl = {(val >= 128), (val == 0), c[0], v[0]};
  endfunction

  // One strobe: optional idle gap, wait (bounded) for ready, then hold process for one edge.
  task automatic beat(input logic [3:0] d, input logic acc, input int gap);
    int guard = 0;
    repeat (gap) @(negedge clk);
    while (!bus.ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) check("ready_timeout", 32'(bus.ready), 32'd1);
    bus.process = 1'b1;
    bus.data_in = d;
    bus.acc_sel = acc;
    @(negedge clk);
    bus.process = 1'b0;
    bus.acc_sel = 1'b0;
  endtask

  // Full operation; expected values come from the table when use_exp, else from the model.
  task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic acc, input int gap,
                        input logic use_exp, input logic [7:0] exp_res,
                        input logic [3:0] exp_fl, input logic abort_in_exec);
    int         r;
    logic [3:0] f;
    int         a_eff;
    a_eff = acc ? m_res : int'(a);
    ref_exec(int'(op), a_eff, int'(b), int'(m_flags[1]), m_res, r, f);
    if (use_exp) begin
      r = int'(exp_res);
      f = exp_fl;
    end
    if (acc) beat(4'($urandom), 1'b1, gap);
    else begin
      beat(a[3:0], 1'b0, gap);
      check({name, "_done_clr"}, 32'(bus.done), 32'd0);
      beat(a[7:4], 1'b0, gap);
    end
    beat(b[3:0], 1'b0, gap);
    beat(b[7:4], 1'b0, gap);
    beat(op, 1'b0, gap);
    check({name, "_exec_ready"}, 32'(bus.ready), 32'd0);
    if (abort_in_exec) bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check({name, "_res"},   32'(bus.result), 32'(r));
    check({name, "_flags"}, 32'(bus.flags),  32'(f));
    check({name, "_done"},  32'(bus.done),   32'd1);
    check({name, "_ready"}, 32'(bus.ready),  32'd1);
    m_res   = r;
    m_flags = f;
  endtask

  vec_t vecs[$];

  initial begin
    // Directed vectors in execution order; flags are {N,Z,C,V}.
    vecs.push_back('{4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001});  // ADD into sign overflow
    vecs.push_back('{4'h1, 8'h10, 8'h20, 1'b0, 8'hF0, 4'b1010});  // SUB with borrow
    vecs.push_back('{4'hD, 8'h20, 8'h20, 1'b0, 8'hF0, 4'b0100});  // CMP equal, result held
    vecs.push_back('{4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110});  // ADD carry out, zero
    vecs.push_back('{4'h8, 8'h00, 8'h00, 1'b1, 8'h01, 4'b0000});  // ADC chained on held result
    vecs.push_back('{4'hC, 8'h81, 8'h00, 1'b0, 8'hC0, 4'b1010});  // ASR
    vecs.push_back('{4'hA, 8'h81, 8'h00, 1'b0, 8'h02, 4'b0010});  // SHL
    vecs.push_back('{4'hB, 8'h81, 8'h00, 1'b0, 8'h40, 4'b0010});  // SHR
    vecs.push_back('{4'hF, 8'h12, 8'h34, 1'b0, 8'h40, 4'b0000});  // NOP keeps result
    vecs.push_back('{4'h1, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b1010});  // SUB borrow sets C
    vecs.push_back('{4'h9, 8'h05, 8'h02, 1'b0, 8'h02, 4'b0000});  // SBB consumes borrow
    vecs.push_back('{4'hE, 8'h55, 8'h00, 1'b0, 8'h00, 4'b0100});  // PASS b
    vecs.push_back('{4'h5, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0100});  // NAND
    vecs.push_back('{4'h7, 8'hA5, 8'h0F, 1'b0, 8'hAA, 4'b1000});  // XOR
    vecs.push_back('{4'h4, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'b1000});  // NOT
    vecs.push_back('{4'h1, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001});  // SUB signed overflow
    vecs.push_back('{4'h6, 8'hF0, 8'h0C, 1'b0, 8'h03, 4'b0000});  // NOR
    vecs.push_back('{4'h2, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000});  // AND
    vecs.push_back('{4'h3, 8'h80, 8'h01, 1'b0, 8'h81, 4'b1000});  // OR

    bus.process = 1'b0;
    bus.abort   = 1'b0;
    bus.acc_sel = 1'b0;
    bus.data_in = '0;
    m_res       = 0;
    m_flags     = '0;

    reset_n = 1'b0;
    #1;
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags",  32'(bus.flags),  32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_ready",  32'(bus.ready),  32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].acc, 0,
             1'b1, vecs[i].exp_res, vecs[i].exp_flags, 1'b0);

    // Idle gaps of five cycles before every beat.
    for (int i = 0; i < 4; i++)
      run_op($sformatf("gap%0d", i), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             1'b0, 5, 1'b0, 8'h00, 4'h0, 1'b0);

    // Abort after three beats, asserted together with a strobe; then the next beat starts op1.
    beat(4'h9, 1'b0, 0);
    beat(4'h9, 1'b0, 0);
    beat(4'h9, 1'b0, 0);
    bus.abort   = 1'b1;
    bus.process = 1'b1;
    bus.data_in = 4'h9;
    @(negedge clk);
    bus.abort   = 1'b0;
    bus.process = 1'b0;
    check("abort_res",   32'(bus.result), 32'(m_res));
    check("abort_flags", 32'(bus.flags),  32'(m_flags));
    check("abort_done",  32'(bus.done),   32'd0);
    check("abort_ready", 32'(bus.ready),  32'd1);
    run_op("post_abort", 4'h0, 8'h21, 8'h13, 1'b0, 0, 1'b1, 8'h34, 4'b0000, 1'b0);

    // Abort during the execute cycle is ignored.
    run_op("abort_exec", 4'h0, 8'h11, 8'h22, 1'b0, 0, 1'b1, 8'h33, 4'b0000, 1'b1);
    run_op("after_abort_exec", 4'h1, 8'h33, 8'h03, 1'b0, 0, 1'b1, 8'h30, 4'b0000, 1'b0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 200; i++)
      run_op("rnd", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 9) == 0), $urandom_range(0, 2), 1'b0, 8'h00, 4'h0, 1'b0);

    // Leave C=1, then reset asynchronously in the middle of op2 collection.
    run_op("pre_rst", 4'h0, 8'hFF, 8'h02, 1'b0, 0, 1'b1, 8'h01, 4'b0010, 1'b0);
    beat(4'h3, 1'b0, 0);
    beat(4'h0, 1'b0, 0);
    beat(4'h4, 1'b0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_result", 32'(bus.result), 32'd0);
    check("async_rst_flags",  32'(bus.flags),  32'd0);
    check("async_rst_done",   32'(bus.done),   32'd0);
    check("async_rst_ready",  32'(bus.ready),  32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    m_res   = 0;
    m_flags = '0;
    run_op("rst_add", 4'h0, 8'h03, 8'h04, 1'b0, 0, 1'b1, 8'h07, 4'b0000, 1'b0);
    run_op("rst_adc", 4'h8, 8'h03, 8'h04, 1'b0, 0, 1'b1, 8'h07, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
